// File: rtl/mcu_spi_slave.sv
// -----------------------------------------------------------------------------
// mcu_spi_slave
//
// SPI mode-0 slave front end that sits between the board MCU's SPI master and
// the system control byte interface. The three SPI pins are brought into the
// clk domain through flop synchronisers. Received bits are assembled into
// bytes that are presented with a one-clk strobe and a frame-start flag. A
// response byte taken from data_out is shifted back to the MCU, MSB first.
//
// Handshake: data_in_strobe is a single-clk pulse. data_in is valid in that
// clk and stays unchanged until the next pulse. data_in_start is high only
// together with the strobe of the first byte of a frame. There is no
// back-pressure; the consumer must accept every strobe. data_out is sampled
// at the SCK falling edge that ends each byte and becomes the next response
// byte.
//
// Parameters:
//   SYNC_STAGES    number of synchroniser flops per SPI input (>= 2)
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   spi_ss_n       slave select from the MCU, active low (async)
//   spi_sck        SPI clock from the MCU, CPOL=0 / CPHA=0 (async)
//   spi_mosi       master-to-slave data, MSB first (async)
//   spi_miso       slave-to-master data, MSB first
//   data_in_strobe one-clk pulse when a received byte is on data_in
//   data_in_start  high with data_in_strobe for the first byte of a frame
//   data_in        last received byte
//   data_out       response byte for the next byte slot
// -----------------------------------------------------------------------------
module mcu_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_ss_n,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       data_in_strobe,
    output logic       data_in_start,
    output logic [7:0] data_in,
    input  logic [7:0] data_out
);

    // A single synchroniser stage is not safe against metastability, and the
    // shift expressions below need at least two stages.
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("mcu_spi_slave: SYNC_STAGES must be at least 2");
    end

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    // fill marks how many synchroniser stages have been reloaded from the
    // pins since reset. Until the last stage holds a real pin sample, the
    // synchronised SS is only its reset value. It must not be mistaken for an
    // idle bus, so that a frame already running when reset was released gets
    // no strobes.
    logic [SYNC_STAGES-1:0] fill;

    logic sck_d;
    logic ss_s;
    logic sck_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            fill      <= '0;
            sck_d     <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sck_d     <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;

    // -------------------------------------------------------------------------
    // Frame-control FSM
    //   ST_WAIT  : after reset, waiting for a genuine high level on SS
    //   ST_IDLE  : SS high, bus idle; SCK ignored
    //   ST_FRAME : SS low, bits are shifted in and out
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   frame_start;
    logic   frame_end;
    logic   rx_take;
    logic   tx_take;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        rx_take     = 1'b0;
        tx_take     = 1'b0;
        case (state)
            ST_WAIT: begin
                if (fill[SYNC_STAGES-1] && ss_s) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // IDLE is only entered with SS high, so seeing it low here is
                // the 1->0 edge. Any SCK edge in this same clk is dropped.
                if (!ss_s) begin
                    state_next  = ST_FRAME;
                    frame_start = 1'b1;
                end
            end
            ST_FRAME: begin
                if (ss_s) begin
                    state_next = ST_IDLE;
                    frame_end  = 1'b1;
                end else begin
                    rx_take = sck_rise;
                    tx_take = sck_fall;
                end
            end
            default: begin
                state_next = ST_WAIT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Shift datapath
    // -------------------------------------------------------------------------
    logic [2:0] bit_cnt;
    logic       first_byte;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] rx_next;

    assign rx_next = {rx_shift[6:0], mosi_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt        <= 3'd0;
            first_byte     <= 1'b1;
            rx_shift       <= 8'h00;
            tx_shift       <= 8'h00;
            spi_miso       <= 1'b0;
            data_in        <= 8'h00;
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
        end else begin
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            if (frame_start) begin
                bit_cnt    <= 3'd0;
                first_byte <= 1'b1;
                tx_shift   <= 8'h00;
                spi_miso   <= 1'b0;
            end else if (frame_end) begin
                // Partial byte is dropped. data_in keeps the last full byte.
                bit_cnt    <= 3'd0;
                first_byte <= 1'b1;
                spi_miso   <= 1'b0;
            end else if (rx_take) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    data_in        <= rx_next;
                    data_in_strobe <= 1'b1;
                    data_in_start  <= first_byte;
                    first_byte     <= 1'b0;
                end
            end else if (tx_take) begin
                if (bit_cnt == 3'd0) begin
                    // Falling edge right after a completed byte: capture the
                    // response for the next byte slot.
                    tx_shift <= data_out;
                    spi_miso <= data_out[7];
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                    spi_miso <= tx_shift[6];
                end
            end
        end
    end

endmodule
